// File: rtl/control_sequencer.sv
// Five-stage instruction control sequencer with a retired-instruction counter.
// Stages: FETCH, DECODE, EXECUTE, WRITEBACK, OUTPUT.
module control_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [7:0]       instr_in,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [2:0]       state,
    output logic [7:0]       instruction,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        FETCH     = 3'b000,
        DECODE    = 3'b001,
        EXECUTE   = 3'b010,
        WRITEBACK = 3'b011,
        OUTPUT    = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;
    logic             is_nop, is_load, is_illegal;
    logic             hs;

    assign instr_ready = (state_q == FETCH) && ena && !rst;
    assign out_valid   = (state_q == OUTPUT);
    assign hs          = instr_valid && instr_ready;
    assign state       = state_q;
    assign instruction = instr_q;
    assign illegal_op  = ill_q;
    assign retired_cnt = cnt_q;

    // Anything not NOP, LOAD or illegal is an R/O-type needing OUTPUT
    always_comb begin
        is_nop     = (instr_q == 8'h00);
        is_load    = (instr_q[3:0] == 4'hA);
        is_illegal = 1'b0;
        case (instr_q[3:0])
            4'h0:                is_illegal = (instr_q[7:4] != 4'h0);
            4'h9, 4'hE, 4'hF:    is_illegal = 1'b1;
            default:             is_illegal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        ill_d   = 1'b0;
        if (ena) begin
            case (state_q)
                FETCH: begin
                    if (hs) begin
                        instr_d = instr_in;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    if (is_nop) begin
                        state_d = FETCH;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (is_illegal) begin
                        state_d = FETCH;
                        ill_d   = 1'b1;
                    end else begin
                        state_d = EXECUTE;
                    end
                end
                EXECUTE: state_d = WRITEBACK;
                WRITEBACK: begin
                    if (is_load) begin
                        state_d = FETCH;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state_d = FETCH;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            instr_q <= 8'h00;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: CNT_W, 8, width of the retired-instruction counter.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 ena  input  1  global enable; when low, all registers SHALL hold.
REQ-006 instr_in  input  8  instruction byte from the program source.
REQ-007 instr_valid  input  1  instr_in is valid.
REQ-008 instr_ready  output  1  the sequencer accepts instr_in this cycle.
REQ-009 out_ready  input  1  the downstream consumer accepts the result.
REQ-010 out_valid  output  1  a result is presented for output.
REQ-011 state  output  3  current stage, driven to the control decode LUT.
REQ-012 instruction  output  8  latched instruction, driven to the control decode LUT.
REQ-013 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-014 retired_cnt  output  CNT_W  count of completed instructions.

Function
REQ-015 State encoding SHALL be: FETCH 000, DECODE 001, EXECUTE 010, WRITEBACK 011, OUTPUT 100.
REQ-016 Opcode class is set by instruction[3:0] as follows:
- NOP: instruction == 8'h00.
- LOAD: nibble A.
- R-type: nibbles 1, 2, 5, 6, 7, B, C, D.
- O-type: nibbles 3, 4, 8.
- Illegal: nibbles 9, E, F, or nibble 0 with a nonzero upper nibble.
REQ-017 instr_ready SHALL equal (state==FETCH) && ena && !rst, combinationally.
REQ-018 FETCH transitions:
- Handshake: instr_valid && instr_ready.
- On handshake, instruction SHALL latch instr_in and the state SHALL go to DECODE.
- With no handshake, FETCH and instruction SHALL hold.
REQ-019 DECODE transitions (NOP, Illegal):
- NOP goes to FETCH.
- Illegal goes to FETCH, and illegal_op is registered high for exactly the next cycle.
REQ-020 DECODE transitions (all other classes): go to EXECUTE.
REQ-021 EXECUTE SHALL always go to WRITEBACK after one cycle.
REQ-022 WRITEBACK transitions: LOAD goes to FETCH; R-type and O-type go to OUTPUT.
REQ-023 out_valid SHALL equal (state==OUTPUT), combinationally.
REQ-024 OUTPUT holds until out_ready && ena, then goes to FETCH.
REQ-025 Minimum latency, counted in cycles from the FETCH handshake edge:
- NOP: 2.
- LOAD: 4.
- R/O-type: 5.
REQ-026 retired_cnt SHALL increment by 1, in exactly one place per instruction:
- NOP: on DECODE->FETCH.
- LOAD: on WRITEBACK->FETCH.
- R/O-type: on the OUTPUT handshake.
REQ-027 Illegal opcodes SHALL NOT increment retired_cnt.
REQ-028 retired_cnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-029 With ena low:
- No transition, no latch and no count occurs.
- illegal_op is 0.
- instr_valid and out_ready are ignored.
REQ-030 Unused state codes 101-111 SHALL go to FETCH on the next edge, with no count and no illegal_op.
REQ-031 instruction SHALL change only on a FETCH handshake.

Reset
REQ-032 While rst is high, all registered outputs SHALL take these values:
- state = FETCH.
- instruction = 8'h00.
- retired_cnt = 0.
- illegal_op = 0.
REQ-033 While rst is high, instr_ready = 0 and out_valid = 0.
REQ-034 Reset asserted in any state SHALL take effect immediately, without waiting for a clock.
REQ-035 An in-flight instruction interrupted by reset SHALL be discarded and not counted.
REQ-036 The first FETCH handshake MAY occur on the first rising edge after rst deasserts.

Verification
REQ-037 Reset, ena=1, instr_in=8'h41 valid, out_ready=1 -> state sequence 000,001,010,011,100,000; out_valid high for one cycle; retired_cnt=1.
REQ-038 instr_in=8'h1A (LOAD) -> state sequence 000,001,010,011,000; out_valid never high; retired_cnt +1.
REQ-039 instr_in=8'h00, then instr_in=8'h0F -> NOP: 000,001,000 with count +1; 0x0F: 000,001,000 with illegal_op pulsed one cycle and count unchanged.
REQ-040 instr_in=8'h83, out_ready low for 5 cycles then high -> OUTPUT held 6 cycles; instruction stays 8'h83; retired_cnt +1 only on the handshake.
REQ-041 ena dropped for 3 cycles during EXECUTE -> state and count frozen; sequence resumes intact when ena returns.
REQ-042 Reset pulsed mid-EXECUTE -> state=000, instruction=00, retired_cnt=0 before the next edge.
REQ-043 Preload retired_cnt=255 by running 255 NOPs, then retire one more instruction -> retired_cnt=0.
